approx_mult_err_monitor: RTL and testbench
==========================================

Name: approx_mult_err_monitor

Overview:
Error-characterisation stage placed directly downstream of the 8x8 approximate multipliers (e.g. the OR-combined 4x4 variants). It accepts operand pairs together with the approximate product the multiplier produced and computes the exact product internally. Over a run of N_SAMPLES accepted samples it accumulates error distance (ED) statistics: sum of ED, maximum ED and count of erroneous results. Used in simulation and on-FPGA sweeps to rank multiplier variants.

Parameters:
N_SAMPLES, 65536, number of samples per run (65536 = exhaustive 8x8 sweep); legal range 1..65536
ACC_W, 32, width of the ED sum accumulator; minimum 16

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  single-cycle pulse; begins a run from IDLE or DONE
in_valid  input  1  sample valid
in_ready  output  1  block can accept a sample this cycle
a  input  8  multiplier operand A (unsigned)
b  input  8  multiplier operand B (unsigned)
r_approx  input  16  approximate product for (a,b)
busy  output  1  high in RUN and DRAIN
done  output  1  high in DONE; results stable
sample_cnt  output  17  samples accepted in current/last run
err_cnt  output  17  samples with ED != 0
err_max  output  16  maximum ED seen
err_sum  output  ACC_W  sum of ED, saturating

Behaviour:
- Reset (async, rst=1): state=IDLE; in_ready, busy, done = 0; all counters/accumulators = 0; pipeline valid bits cleared. Applies mid-run; the run is discarded.
- States: IDLE -> RUN on start; RUN -> DRAIN when sample_cnt reaches N_SAMPLES (on the accepting edge); DRAIN -> DONE once both pipeline stages are empty; DONE -> RUN on start. start in RUN/DRAIN is ignored.
- On start (IDLE or DONE): sample_cnt, err_cnt, err_max, err_sum cleared in the same edge as the transition to RUN.
- Handshake: in_ready = (state==RUN) && (sample_cnt < N_SAMPLES). Sample accepted when in_valid && in_ready; sample_cnt increments on acceptance. in_valid without in_ready is a no-op; no samples lost or duplicated across gaps.
- Pipeline, 2 stages, no stalls:
  stage 1 (acceptance edge): register exact = a*b (16-bit unsigned) and r_approx, set v1.
  stage 2 (next edge, if v1): diff = exact - r_approx as 17-bit signed; ED = |diff| (16-bit, max 65535); update statistics, v2 pulses.
  A sample accepted at edge t is reflected in err_* at edge t+2.
- Statistics update on stage 2: err_cnt += (ED!=0); err_max = max(err_max, ED); err_sum += ED, saturating at 2^ACC_W-1 (never wraps).
- DRAIN lasts exactly 2 cycles after the final acceptance; done asserts on the following edge with all statistics final.
- Outputs hold their values in DONE and IDLE until the next start or reset.

Optional Feature:
ERR_SQ_EN: when defined, adds output err_sq_sum (48 bits) = saturating sum of ED*ED, updated in stage 2 alongside err_sum, cleared on start/reset; used for MSE. When not defined, the port and its multiplier logic are absent and all other behaviour is identical.

Test Plan:
- Exact reference: N_SAMPLES=16, r_approx=a*b for 16 random pairs, in_valid held high -> done 2 cycles after the 16th accept; sample_cnt=16, err_cnt=0, err_max=0, err_sum=0.
- Constant offset: N_SAMPLES=4, r_approx=a*b+3 and a*b-5 alternating -> err_cnt=4, err_max=5, err_sum=16.
- Worst case ED: a=255, b=255, r_approx=0, N_SAMPLES=1 -> err_max=65025, err_sum=65025; with ERR_SQ_EN err_sq_sum=4228250625.
- Saturation: ACC_W=16, N_SAMPLES=2, two samples with ED=65025 -> err_sum=65535, err_max=65025.
- Backpressure/gaps: in_valid toggling 1,0,0,1,... plus start pulses during RUN -> start ignored; only in_valid&&in_ready cycles counted; in_ready=0 once sample_cnt=N_SAMPLES.
- Reset mid-run after 7 accepts -> all outputs 0, IDLE; subsequent start + full run matches golden model; start in DONE clears and reruns.

Source files
------------

// File: rtl/approx_mult_err_monitor_if.sv
// rtl/approx_mult_err_monitor_if.sv - sample stream into the approximate multiplier error monitor
interface approx_mult_err_monitor_if;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] r_approx;

    modport master (
        output in_valid,
        output a,
        output b,
        output r_approx,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  a,
        input  b,
        input  r_approx,
        output in_ready
    );
endinterface

// File: rtl/approx_mult_err_monitor.sv
// rtl/approx_mult_err_monitor.sv - error distance statistics for 8x8 approximate multipliers
// Optional ERR_SQ_EN adds the saturating sum of squared error distance (err_sq_sum).
module approx_mult_err_monitor #(
    parameter int N_SAMPLES = 65536,
    parameter int ACC_W     = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    approx_mult_err_monitor_if.slave  smp,
    output logic                      busy,
    output logic                      done,
    output logic [16:0]               sample_cnt,
    output logic [16:0]               err_cnt,
    output logic [15:0]               err_max,
    output logic [ACC_W-1:0]          err_sum
`ifdef ERR_SQ_EN
    ,
    output logic [47:0]               err_sq_sum
`endif
);

    localparam logic [16:0] N_CNT = 17'(N_SAMPLES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state, state_n;
    logic   clear_stats;
    logic   accept;
    logic   last_accept;

    logic        v1;
    logic [15:0] exact_q;
    logic [15:0] rap_q;
    logic        v2;
    logic [15:0] ed_q;

    logic [15:0]    ed;
    logic [ACC_W:0] sum_ext;
    logic [ACC_W-1:0] sum_sat;

    assign smp.in_ready = (state == RUN) && (sample_cnt < N_CNT);
    assign accept       = smp.in_valid && smp.in_ready;
    assign last_accept  = accept && (sample_cnt == (N_CNT - 17'd1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Leaving DRAIN once stage 1 is empty lets the final sample retire from
    // stage 2 on the same edge that raises done.
    always_comb begin
        state_n     = state;
        clear_stats = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n     = RUN;
                    clear_stats = 1'b1;
                end
            end
            RUN: begin
                if (last_accept) begin
                    state_n = DRAIN;
                end
            end
            DRAIN: begin
                if (!v1) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    state_n     = RUN;
                    clear_stats = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign busy = (state == RUN) || (state == DRAIN);
    assign done = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_cnt <= 17'd0;
        end else if (clear_stats) begin
            sample_cnt <= 17'd0;
        end else if (accept) begin
            sample_cnt <= sample_cnt + 17'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1      <= 1'b0;
            exact_q <= 16'd0;
            rap_q   <= 16'd0;
        end else begin
            v1 <= accept;
            if (accept) begin
                exact_q <= 16'(smp.a) * 16'(smp.b);
                rap_q   <= smp.r_approx;
            end
        end
    end

    // Magnitude of the 17-bit signed difference; always fits in 16 bits.
    assign ed = (exact_q >= rap_q) ? (exact_q - rap_q) : (rap_q - exact_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2   <= 1'b0;
            ed_q <= 16'd0;
        end else begin
            v2 <= v1;
            if (v1) begin
                ed_q <= ed;
            end
        end
    end

    assign sum_ext = {1'b0, err_sum} + (ACC_W+1)'(ed_q);
    assign sum_sat = sum_ext[ACC_W] ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt <= 17'd0;
            err_max <= 16'd0;
            err_sum <= '0;
        end else if (clear_stats) begin
            err_cnt <= 17'd0;
            err_max <= 16'd0;
            err_sum <= '0;
        end else if (v2) begin
            if (ed_q != 16'd0) begin
                err_cnt <= err_cnt + 17'd1;
            end
            if (ed_q > err_max) begin
                err_max <= ed_q;
            end
            err_sum <= sum_sat;
        end
    end

`ifdef ERR_SQ_EN
    logic [31:0] ed_sq;
    logic [48:0] sq_ext;

    assign ed_sq  = 32'(ed_q) * 32'(ed_q);
    assign sq_ext = {1'b0, err_sq_sum} + 49'(ed_sq);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_sq_sum <= 48'd0;
        end else if (clear_stats) begin
            err_sq_sum <= 48'd0;
        end else if (v2) begin
            err_sq_sum <= sq_ext[48] ? {48{1'b1}} : sq_ext[47:0];
        end
    end
`endif

endmodule

// File: tb/tb_approx_mult_err_monitor.sv
// tb/tb_approx_mult_err_monitor.sv - directed bench for approx_mult_err_monitor
module tb_approx_mult_err_monitor;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        tv = 1'b0;
    logic [7:0]  ta = 8'd0;
    logic [7:0]  tb_b = 8'd0;
    logic [15:0] tr = 16'd0;
    logic [3:0]  st = 4'd0;
    int          sel = 0;

    int checks = 0;
    int errors = 0;

    // index 0: N=16, 1: N=4, 2: N=1, 3: N=2 with 16-bit accumulator
    approx_mult_err_monitor_if if0 ();
    approx_mult_err_monitor_if if1 ();
    approx_mult_err_monitor_if if2 ();
    approx_mult_err_monitor_if if3 ();

    assign if0.in_valid = tv; assign if0.a = ta; assign if0.b = tb_b; assign if0.r_approx = tr;
    assign if1.in_valid = tv; assign if1.a = ta; assign if1.b = tb_b; assign if1.r_approx = tr;
    assign if2.in_valid = tv; assign if2.a = ta; assign if2.b = tb_b; assign if2.r_approx = tr;
    assign if3.in_valid = tv; assign if3.a = ta; assign if3.b = tb_b; assign if3.r_approx = tr;

    logic [3:0]  bsy, dn;
    logic [16:0] sc [4];
    logic [16:0] ec [4];
    logic [15:0] em [4];
    logic [31:0] es [3];
    logic [15:0] es3;
`ifdef ERR_SQ_EN
    logic [47:0] sq [4];
`endif

    approx_mult_err_monitor #(.N_SAMPLES(16), .ACC_W(32)) u0 (
        .clk(clk), .rst(rst), .start(st[0]), .smp(if0.slave),
        .busy(bsy[0]), .done(dn[0]), .sample_cnt(sc[0]), .err_cnt(ec[0]),
        .err_max(em[0]), .err_sum(es[0])
`ifdef ERR_SQ_EN
        , .err_sq_sum(sq[0])
`endif
    );

    approx_mult_err_monitor #(.N_SAMPLES(4), .ACC_W(32)) u1 (
        .clk(clk), .rst(rst), .start(st[1]), .smp(if1.slave),
        .busy(bsy[1]), .done(dn[1]), .sample_cnt(sc[1]), .err_cnt(ec[1]),
        .err_max(em[1]), .err_sum(es[1])
`ifdef ERR_SQ_EN
        , .err_sq_sum(sq[1])
`endif
    );

    approx_mult_err_monitor #(.N_SAMPLES(1), .ACC_W(32)) u2 (
        .clk(clk), .rst(rst), .start(st[2]), .smp(if2.slave),
        .busy(bsy[2]), .done(dn[2]), .sample_cnt(sc[2]), .err_cnt(ec[2]),
        .err_max(em[2]), .err_sum(es[2])
`ifdef ERR_SQ_EN
        , .err_sq_sum(sq[2])
`endif
    );

    approx_mult_err_monitor #(.N_SAMPLES(2), .ACC_W(16)) u3 (
        .clk(clk), .rst(rst), .start(st[3]), .smp(if3.slave),
        .busy(bsy[3]), .done(dn[3]), .sample_cnt(sc[3]), .err_cnt(ec[3]),
        .err_max(em[3]), .err_sum(es3)
`ifdef ERR_SQ_EN
        , .err_sq_sum(sq[3])
`endif
    );

    logic rdy;
    always_comb begin
        rdy = 1'b0;
        case (sel)
            0: rdy = if0.in_ready;
            1: rdy = if1.in_ready;
            2: rdy = if2.in_ready;
            3: rdy = if3.in_ready;
            default: rdy = 1'b0;
        endcase
    end

    int     m_cnt, m_err, m_max;
    longint m_sum;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_cnt = 0; m_err = 0; m_max = 0; m_sum = 0;
    endtask

    task automatic send(input logic [7:0] xa, input logic [7:0] xb, input logic [15:0] xr);
        int p, r, e;
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            ta = xa; tb_b = xb; tr = xr; tv = 1'b1;
            if (rdy) begin
                @(posedge clk);
                #1 tv = 1'b0;
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            tv = 1'b0;
            check("send_timeout", 64'd0, 64'd1);
        end
        p = int'(xa) * int'(xb);
        r = int'(xr);
        e = (p >= r) ? p - r : r - p;
        m_cnt++;
        if (e != 0) m_err++;
        if (e > m_max) m_max = e;
        m_sum += longint'(e);
    endtask

    task automatic gap();
        @(negedge clk);
        tv = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input int idx);
        @(negedge clk);
        tv = 1'b0;
        st[idx] = 1'b1;
        @(posedge clk);
        #1 st[idx] = 1'b0;
    endtask

    task automatic check_u0_model(input string tag);
        check({tag, "_sample_cnt"}, 64'(sc[0]), 64'(m_cnt));
        check({tag, "_err_cnt"}, 64'(ec[0]), 64'(m_err));
        check({tag, "_err_max"}, 64'(em[0]), 64'(m_max));
        check({tag, "_err_sum"}, 64'(es[0]), 64'(m_sum));
    endtask

    initial begin
        logic [7:0] ra, rb;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 64'(if0.in_ready), 64'd0);
        check("rst_busy", 64'(bsy), 64'd0);
        check("rst_done", 64'(dn), 64'd0);
        check("rst_sample_cnt", 64'(sc[0]), 64'd0);
        check("rst_err_sum", 64'(es[0]), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("idle_ready", 64'(if0.in_ready), 64'd0);

        // exact reference: 16 random pairs, r_approx = a*b
        sel = 0;
        pulse_start(0);
        check("exact_busy", 64'(bsy[0]), 64'd1);
        check("exact_ready", 64'(if0.in_ready), 64'd1);
        model_clear();
        for (int i = 0; i < 16; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            send(ra, rb, 16'(ra) * 16'(rb));
        end
        check("exact_ready_full", 64'(if0.in_ready), 64'd0);
        check("exact_done_t0", 64'(dn[0]), 64'd0);
        @(posedge clk); #1;
        check("exact_done_t1", 64'(dn[0]), 64'd0);
        check("exact_busy_t1", 64'(bsy[0]), 64'd1);
        @(posedge clk); #1;
        check("exact_done_t2", 64'(dn[0]), 64'd1);
        check("exact_busy_t2", 64'(bsy[0]), 64'd0);
        check("exact_sample_cnt", 64'(sc[0]), 64'd16);
        check("exact_err_cnt", 64'(ec[0]), 64'd0);
        check("exact_err_max", 64'(em[0]), 64'd0);
        check("exact_err_sum", 64'(es[0]), 64'd0);

        // constant offset: +3, -5 alternating
        sel = 1;
        pulse_start(1);
        send(8'd3, 8'd4, 16'd15);
        send(8'd5, 8'd6, 16'd25);
        send(8'd7, 8'd8, 16'd59);
        send(8'd9, 8'd10, 16'd85);
        repeat (2) @(posedge clk);
        #1;
        check("ofs_done", 64'(dn[1]), 64'd1);
        check("ofs_err_cnt", 64'(ec[1]), 64'd4);
        check("ofs_err_max", 64'(em[1]), 64'd5);
        check("ofs_err_sum", 64'(es[1]), 64'd16);

        // worst case ED, single sample
        sel = 2;
        pulse_start(2);
        send(8'd255, 8'd255, 16'd0);
        repeat (2) @(posedge clk);
        #1;
        check("worst_done", 64'(dn[2]), 64'd1);
        check("worst_err_max", 64'(em[2]), 64'd65025);
        check("worst_err_sum", 64'(es[2]), 64'd65025);
        check("worst_err_cnt", 64'(ec[2]), 64'd1);
`ifdef ERR_SQ_EN
        check("worst_err_sq_sum", 64'(sq[2]), 64'd4228250625);
`endif

        // saturation with a 16-bit accumulator
        sel = 3;
        pulse_start(3);
        send(8'd255, 8'd255, 16'd0);
        send(8'd255, 8'd255, 16'd0);
        repeat (2) @(posedge clk);
        #1;
        check("sat_done", 64'(dn[3]), 64'd1);
        check("sat_err_sum", 64'(es3), 64'd65535);
        check("sat_err_max", 64'(em[3]), 64'd65025);

        // gaps and ignored start pulses on the N=4 instance
        sel = 1;
        pulse_start(1);
        check("gap_cleared", 64'(es[1]), 64'd0);
        send(8'd10, 8'd10, 16'd100);
        gap();
        pulse_start(1);
        check("gap_start_ignored", 64'(sc[1]), 64'd1);
        check("gap_busy", 64'(bsy[1]), 64'd1);
        send(8'd20, 8'd20, 16'd401);
        gap();
        gap();
        check("gap_sample_cnt", 64'(sc[1]), 64'd2);
        send(8'd30, 8'd30, 16'd890);
        pulse_start(1);
        gap();
        send(8'd40, 8'd40, 16'd1600);
        check("gap_ready_full", 64'(if1.in_ready), 64'd0);
        pulse_start(1);
        @(posedge clk); #1;
        check("gap_done", 64'(dn[1]), 64'd1);
        @(negedge clk);
        tv = 1'b1;
        @(posedge clk); #1;
        tv = 1'b0;
        check("gap_no_extra", 64'(sc[1]), 64'd4);
        check("gap_err_cnt", 64'(ec[1]), 64'd2);
        check("gap_err_max", 64'(em[1]), 64'd10);
        check("gap_err_sum", 64'(es[1]), 64'd11);

        // reset mid-run after 7 accepts
        sel = 0;
        pulse_start(0);
        for (int i = 0; i < 7; i++) begin
            send(8'(i + 1), 8'd9, 16'd0);
        end
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_sample_cnt", 64'(sc[0]), 64'd0);
        check("mid_rst_err_sum", 64'(es[0]), 64'd0);
        check("mid_rst_err_max", 64'(em[0]), 64'd0);
        check("mid_rst_busy", 64'(bsy[0]), 64'd0);
        check("mid_rst_ready", 64'(if0.in_ready), 64'd0);
        check("mid_rst_other_done", 64'(dn[1]), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_idle", 64'(bsy[0]), 64'd0);

        pulse_start(0);
        model_clear();
        for (int i = 0; i < 16; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            send(ra, rb, 16'($urandom_range(0, 65535)));
        end
        repeat (2) @(posedge clk);
        #1;
        check("rerun_done", 64'(dn[0]), 64'd1);
        check_u0_model("rerun");

        // start from DONE clears and reruns
        pulse_start(0);
        check("restart_cleared_cnt", 64'(sc[0]), 64'd0);
        check("restart_cleared_sum", 64'(es[0]), 64'd0);
        check("restart_done_low", 64'(dn[0]), 64'd0);
        model_clear();
        for (int i = 0; i < 16; i++) begin
            if (i % 3 == 0) begin
                gap();
            end
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            send(ra, rb, (16'(ra) * 16'(rb)) | 16'(i));
        end
        repeat (2) @(posedge clk);
        #1;
        check("restart_done", 64'(dn[0]), 64'd1);
        check_u0_model("restart");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
